// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared FSM states, port indices and RAM index bounds for dram_arbiter.
package dram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic P_CPU      = 1'b0;
    localparam logic P_DMA      = 1'b1;
    localparam int   RAM_IDX_LO = 2;
    localparam int   RAM_IDX_HI = 6;
endpackage

// File: rtl/dram_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way picker; a tie goes to the port that did not win last,
// or always to the CPU port when fixed is high.
module rr_pick2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic       grant_id,
    output logic       any
);
    always_comb begin
        any      = |req;
        grant_id = (&req) ? (fixed ? P_CPU : ~last) : req[P_DMA];
    end
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port round-robin sequencer for the 32x32 data RAM (IDLE/ACCESS/RESP).
// Define DRAM_ARB_FIXED_PRIO_EN to make the CPU port win every contest.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout
);
    state_t            state, state_n;
    logic              fixed, grant_id, any;
    logic              l_we, mis, win_id, last_grant;
    logic [ADDR_W-1:0] l_addr, sel_addr;
    logic [DATA_W-1:0] l_wdata;

`ifdef DRAM_ARB_FIXED_PRIO_EN
    assign fixed = 1'b1;
`else
    assign fixed = 1'b0;
`endif

    rr_pick2 u_pick (
        .req      (req),
        .last     (last_grant),
        .fixed    (fixed),
        .grant_id (grant_id),
        .any      (any)
    );

    assign sel_addr = grant_id ? addr1 : addr0;

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = (state == IDLE)   ? (any ? ACCESS : IDLE) :
                  (state == ACCESS) ? RESP : IDLE;
    end

    // mem_we is decoded from state so an asynchronous reset kills it immediately
    assign busy       = (state == ACCESS) || (state == RESP);
    assign mem_we     = (state == ACCESS) && l_we && !mis;
    assign mem_addr   = l_addr;
    assign mem_datain = l_wdata;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            l_we       <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            mis        <= 1'b0;
            win_id     <= P_CPU;
            last_grant <= P_DMA;
            ack        <= 2'b00;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && any) begin
                l_we    <= we[grant_id];
                l_addr  <= sel_addr;
                l_wdata <= grant_id ? wdata1 : wdata0;
                mis     <= sel_addr[RAM_IDX_LO-1:0] != '0;
                win_id  <= grant_id;
            end
            if (state == ACCESS)
                rdata <= (l_we || mis) ? '0 : mem_dataout;
            if (state == RESP)
                last_grant <= win_id;
            ack <= (state == ACCESS) ? (2'b01 << win_id) : 2'b00;
            err <= (state == ACCESS) && mis;
        end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized self-checking bench with a transaction-level reference model.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0, we = '0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]  ack;
    logic        err, busy, mem_we;
    logic [31:0] rdata, mem_addr, mem_datain, mem_dataout;

    logic [31:0] ram [32];
    logic [31:0] mm  [32];
    bit          m_last;
    bit          fixed_prio;
    int          checks = 0, errors = 0, we_cnt = 0, we_bad = 0;

    always #5 clock = ~clock;

    dram_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout)
    );

    assign mem_dataout = ram[mem_addr[RAM_IDX_HI:RAM_IDX_LO]];
    always @(posedge clock) if (mem_we) ram[mem_addr[RAM_IDX_HI:RAM_IDX_LO]] <= mem_datain;

    always @(negedge clock) begin
        if (mem_we) we_cnt++;
        if (mem_we && !busy) we_bad++;
    end

    function automatic logic [31:0] img(int i);
        if (i == 0) return 32'hbf800000;
        if (i == 14) return 32'h000000a3;
        if (i == 15) return 32'h00000027;
        return 32'h1000_0000 + i * 32'h0001_0101;
    endfunction

    // Reference: one whole transaction at once, from byte address arithmetic
    function automatic void model_txn(bit w, logic [31:0] a, logic [31:0] d,
                                      output logic [31:0] rd, output logic er);
        int idx = int'((a / 4) % 32);
        er = (a % 4) != 0;
        rd = 32'h0;
        if (!er && w) mm[idx] = d;
        if (!er && !w) rd = mm[idx];
    endfunction

    function automatic bit pick(bit r0, bit r1);
        if (r0 && r1) return fixed_prio ? 1'b0 : !m_last;
        return r1;
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(int p, bit w, logic [31:0] a, logic [31:0] d);
        req[p] = 1'b1;
        we[p]  = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
    endtask

    task automatic serve(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (ack == 2'b00 && n < 10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cycle();
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        reset = 1'b0;
        m_last = 1'b1;
        cycle();
    endtask

    task automatic test_first_read();
        int n, w0;
        logic [31:0] er_d; logic er_e;
        w0 = we_cnt;
        drive(0, 1'b0, 32'h0, 32'h0);
        serve(n);
        model_txn(1'b0, 32'h0, 32'h0, er_d, er_e);
        checks++; if (n !== 2) begin errors++; $display("FAIL first_latency got %0d want 2", n); end
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL first_ack got %b want 01", ack); end
        checks++; if (rdata !== 32'hbf800000 || rdata !== er_d) begin errors++; $display("FAIL first_rdata got %h want bf800000", rdata); end
        checks++; if (err !== er_e) begin errors++; $display("FAIL first_err got %b want %b", err, er_e); end
        req = '0; m_last = 1'b0;
        cycle();
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL first_ack_pulse got %b want 00", ack); end
        checks++; if (we_cnt !== w0) begin errors++; $display("FAIL first_no_write got %0d want %0d", we_cnt - w0, 0); end
    endtask

    task automatic test_write_read();
        int n, w0;
        logic [31:0] er_d; logic er_e;
        w0 = we_cnt;
        drive(1, 1'b1, 32'h40, 32'hdeadbeef);
        serve(n);
        model_txn(1'b1, 32'h40, 32'hdeadbeef, er_d, er_e);
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL wr_ack got %b want 10", ack); end
        checks++; if (rdata !== er_d) begin errors++; $display("FAIL wr_rdata got %h want %h", rdata, er_d); end
        req = '0; m_last = 1'b1;
        cycle();
        drive(0, 1'b0, 32'h40, 32'h0);
        serve(n);
        model_txn(1'b0, 32'h40, 32'h0, er_d, er_e);
        checks++; if (ack !== 2'b01 || n !== 2) begin errors++; $display("FAIL rd_ack got %b/%0d want 01/2", ack, n); end
        checks++; if (rdata !== 32'hdeadbeef || rdata !== er_d) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rdata); end
        checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL wr_pulses got %0d want 1", we_cnt - w0); end
        req = '0; m_last = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        bit w;
        logic [31:0] er_d; logic er_e;
        drive(0, 1'b0, 32'h38, 32'h0);
        drive(1, 1'b0, 32'h3c, 32'h0);
        for (int k = 0; k < 4; k++) begin
            w = pick(1'b1, 1'b1);
            serve(n);
            model_txn(1'b0, w ? 32'h3c : 32'h38, 32'h0, er_d, er_e);
            checks++; if (ack !== (2'b01 << w)) begin errors++; $display("FAIL b2b_ack[%0d] got %b want %b", k, ack, 2'b01 << w); end
            checks++; if (rdata !== er_d) begin errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", k, rdata, er_d); end
            checks++; if (n !== (k == 0 ? 2 : 3)) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", k, n, k == 0 ? 2 : 3); end
            m_last = w;
        end
        req = '0;
        cycle();
    endtask

    task automatic test_misaligned();
        int n, w0;
        logic [31:0] er_d; logic er_e;
        w0 = we_cnt;
        drive(0, 1'b1, 32'h41, 32'h1234);
        serve(n);
        model_txn(1'b1, 32'h41, 32'h1234, er_d, er_e);
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL mis_ack got %b want 01", ack); end
        checks++; if (err !== 1'b1 || err !== er_e) begin errors++; $display("FAIL mis_err got %b want 1", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h want 0", rdata); end
        req = '0; m_last = 1'b0;
        cycle();
        checks++; if (we_cnt !== w0) begin errors++; $display("FAIL mis_mem_we got %0d want 0", we_cnt - w0); end
        drive(0, 1'b0, 32'h40, 32'h0);
        serve(n);
        model_txn(1'b0, 32'h40, 32'h0, er_d, er_e);
        checks++; if (rdata !== er_d) begin errors++; $display("FAIL mis_word16 got %h want %h", rdata, er_d); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_clear_err got %b want 0", err); end
        req = '0;
        cycle();
    endtask

    task automatic test_reset_mid_access();
        int n;
        logic [31:0] er_d; logic er_e;
        drive(1, 1'b1, 32'h44, 32'hcafef00d);
        cycle();
        checks++; if (mem_we !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got we=%b busy=%b want 1/1", mem_we, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b want 00", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        req = '0;
        cycle();
        reset = 1'b0;
        m_last = 1'b1;
        drive(0, 1'b0, 32'h44, 32'h0);
        drive(1, 1'b0, 32'h38, 32'h0);
        serve(n);
        model_txn(1'b0, 32'h44, 32'h0, er_d, er_e);
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rst_tie_ack got %b want 01", ack); end
        checks++; if (rdata !== er_d) begin errors++; $display("FAIL rst_nowrite got %h want %h", rdata, er_d); end
        m_last = 1'b0;
        req[0] = 1'b0;
        serve(n);
        model_txn(1'b0, 32'h38, 32'h0, er_d, er_e);
        checks++; if (ack !== 2'b10 || n !== 3) begin errors++; $display("FAIL rst_second got %b/%0d want 10/3", ack, n); end
        checks++; if (rdata !== er_d) begin errors++; $display("FAIL rst_second_rdata got %h want %h", rdata, er_d); end
        m_last = 1'b1;
        req = '0;
        cycle();
    endtask

    task automatic test_random();
        bit pd [2];
        bit tw [2];
        logic [31:0] ta [2], td [2];
        logic [31:0] er_d; logic er_e;
        int n, w0, exp_we;
        bit w, first;
        pd[0] = 0; pd[1] = 0;
        w0 = we_cnt; exp_we = 0; first = 1;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pd[p] && ($urandom_range(0, 1) == 1 || (p == 1 && !pd[0]))) begin
                    pd[p] = 1;
                    tw[p] = 1'($urandom_range(0, 1));
                    ta[p] = ($urandom & 32'hffff_ff80) | (32'($urandom_range(0, 31)) << 2)
                          | ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
                    td[p] = $urandom;
                    drive(p, tw[p], ta[p], td[p]);
                end
            end
            w = pick(pd[0], pd[1]);
            serve(n);
            model_txn(tw[w], ta[w], td[w], er_d, er_e);
            if (tw[w] && !er_e) exp_we++;
            checks++; if (n !== (first ? 2 : 3)) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", it, n, first ? 2 : 3); end
            checks++; if (ack !== (2'b01 << w)) begin errors++; $display("FAIL rnd_ack[%0d] got %b want %b", it, ack, 2'b01 << w); end
            checks++; if (err !== er_e) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", it, err, er_e); end
            checks++; if (rdata !== er_d) begin errors++; $display("FAIL rnd_rdata[%0d] got %h want %h", it, rdata, er_d); end
            m_last = w;
            pd[w] = 0;
            req[w] = 1'b0;
            first = 0;
        end
        req = '0;
        cycle();
        checks++; if (we_cnt - w0 !== exp_we) begin errors++; $display("FAIL rnd_write_pulses got %0d want %0d", we_cnt - w0, exp_we); end
        checks++; if (we_bad !== 0) begin errors++; $display("FAIL mem_we_outside_busy got %0d want 0", we_bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin
            ram[i] = img(i);
            mm[i]  = img(i);
        end
        test_reset();
        test_first_read();
        test_write_read();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 32x32 data RAM: combinational read, write on rising clock edge, word index `addr[6:2]`.
- Port 0 is the CPU load/store path; port 1 is the loader/debug DMA path.
- Serialises accesses through a 3-state FSM with round-robin fairness, registers read data and returns a one-cycle ack per transaction.

Parameters:
- DATA_W, 32, data width of requesters and RAM.
- ADDR_W, 32, byte-address width; only bits [6:2] reach the RAM index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-port request; held high until that port's ack.
- we  in  2  per-port write enable, valid while req is high.
- addr0, addr1  in  ADDR_W  per-port byte address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- ack  out  2  one-cycle completion pulse, one-hot.
- err  out  1  valid with ack: misaligned access.
- rdata  out  DATA_W  registered read data, valid while ack is high.
- busy  out  1  high in ACCESS and RESP.
- mem_addr  out  ADDR_W  to RAM `addr`.
- mem_datain  out  DATA_W  to RAM `datain`.
- mem_we  out  1  to RAM `we`.
- mem_dataout  in  DATA_W  from RAM `dataout`.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, ack=0, err=0, rdata=0, busy=0, mem_we=0, latched request fields=0, last_grant=1 (port 0 wins the first contest).
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick a winner and latch that port's we, addr and wdata, plus win_id and mis=(addr[1:0]!=0). Go to ACCESS.
  - Winner selection: if only one port requests, it wins. If both request, the port != last_grant wins.
- ACCESS (exactly 1 cycle):
  - mem_addr=latched addr; mem_datain=latched wdata; mem_we=latched we & ~mis.
  - The RAM write commits on the edge ending ACCESS.
  - On that same edge, rdata <= mem_dataout for reads, or rdata <= 0 for writes and misaligned accesses.
  - err <= mis; ack[win_id] <= 1. Go to RESP.
- RESP (exactly 1 cycle):
  - ack and err are visible. On exit, ack <= 0, err <= 0, last_grant <= win_id. Go to IDLE.
- Outside ACCESS: mem_we=0; mem_addr and mem_datain hold their latched values (don't-care to the RAM).
- Latency: req sampled at edge k leads to ack high during cycle k+2. Peak throughput is one access per 3 cycles.
- Requester rule: deassert req at the edge ending the ack cycle, or present the next request. req changes during ACCESS/RESP are ignored. A req seen high in IDLE is a new transaction.
- Simultaneous continuous requests alternate 0,1,0,1.
- A read of the word being written in the same transaction is impossible: one port per transaction.
- rdata holds its value after ack until the next ACCESS exit.
- Reset asserted mid-ACCESS: the write may or may not commit depending on the edge relation; the arbiter guarantees mem_we=0 as soon as reset asserts.

Optional Feature:
- DRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a contest; last_grant is still updated but unused; port 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package dram_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP} as 2-bit codes 0/1/2;
  - port index constants P_CPU=0, P_DMA=1;
  - RAM_IDX_LO=2, RAM_IDX_HI=6.
- One sub-module, rr_pick2: combinational 2-way picker with inputs req[1:0], last, fixed and outputs grant_id and any. Under DRAM_ARB_FIXED_PRIO_EN, `fixed` is tied high.
- The FSM and latches stay in dram_arbiter.

Test Plan:
- Reset, then port 0 reads addr 0 with the RAM in its power-up image → ack=2'b01 two cycles after req, rdata=32'hbf800000, err=0, mem_we never high.
- Port 1 writes 32'hdeadbeef to addr 32'h40, then port 0 reads 32'h40 → exactly one mem_we pulse, during ACCESS only; second ack=2'b01 with rdata=32'hdeadbeef.
- Both ports hold req with reads of 32'h38 and 32'h3c → grants alternate 0,1,0,1; rdata alternates 32'h000000a3 and 32'h00000027; each ack spacing is 3 cycles.
- Port 0 writes 32'h1234 to misaligned addr 32'h41 → ack with err=1, rdata=0, mem_we stays 0, a subsequent read of word 16 is unchanged.
- Assert reset asynchronously mid-ACCESS of a port 1 write → mem_we, ack, busy drop to 0 before the next edge; after release, a port 0 and port 1 tie is won by port 0.
- With DRAM_ARB_FIXED_PRIO_EN defined, both ports hold req for 12 cycles → only port 0 receives acks (4 acks); port 1 receives none.
